alu_bist_ctrl: RTL



---
 rtl/alu_bist_pkg.sv | 21 ++
 rtl/alu_bist_misr.sv | 32 +++
 rtl/alu_bist_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_bist_pkg.sv
// rtl/alu_bist_pkg.sv - shared states, polynomials and LFSR step for the ALU BIST controller
package alu_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_CMP  = 3'd3,
        ST_DONE = 3'd4
    } bist_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam int          OP_COUNT  = 4;

    // Galois form: shift left, fold the polynomial back in when the MSB falls out
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// rtl/alu_bist_misr.sv - 16-bit MISR compacting a data word plus a carry bit per cycle
module alu_bist_misr
    import alu_bist_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [15:0] i_data,
    input  logic        i_cout,
    output logic [15:0] o_sig
);

    logic [15:0] r_misr;
    logic [15:0] w_shift;

    assign w_shift = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? MISR_POLY : 16'h0);
    assign o_sig   = r_misr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_misr <= SEED;
        end else if (i_load) begin
            r_misr <= SEED;
        end else if (i_en) begin
            r_misr <= w_shift ^ i_data ^ {15'b0, i_cout};
        end
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// rtl/alu_bist_ctrl.sv - ALU BIST sequencer: LFSR operands, four opcodes per pair, MISR signature check
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int          PATTERN_COUNT = 256,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_1D2B,
    parameter logic [15:0] MISR_SEED     = 16'hFFFF,
    parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_alu_result,
    input  logic        i_alu_cout,
    output logic [15:0] o_alu_a,
    output logic [15:0] o_alu_b,
    output logic [1:0]  o_alu_sel,
    output logic        o_test_mode,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [15:0] o_signature
);

    localparam int               CNT_W    = $clog2(PATTERN_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'(PATTERN_COUNT - 1);
    localparam logic [1:0]       LAST_OP  = 2'(OP_COUNT - 1);

    if (LFSR_SEED == 32'h0) begin : g_seed_chk
        $error("alu_bist_ctrl: LFSR_SEED must be nonzero");
    end
    if (PATTERN_COUNT < 1 || PATTERN_COUNT > 65535) begin : g_count_chk
        $error("alu_bist_ctrl: PATTERN_COUNT out of range 1..65535");
    end

    bist_state_e      r_state;
    logic             r_start;
    logic [31:0]      r_lfsr;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_alu_a;
    logic [15:0]      r_alu_b;
    logic [1:0]       r_alu_sel;
    logic             r_pass;
    logic [31:0]      w_lfsr_next;
    logic [15:0]      w_sig;

    assign w_lfsr_next = lfsr_step(r_lfsr);

    alu_bist_misr #(
        .SEED (MISR_SEED)
    ) u_misr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (r_state == ST_INIT),
        .i_en    (r_state == ST_RUN),
        .i_data  (i_alu_result),
        .i_cout  (i_alu_cout),
        .o_sig   (w_sig)
    );

    // start is captured only where it can act, so pulses while busy vanish
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_start   <= 1'b0;
            r_lfsr    <= LFSR_SEED;
            r_cnt     <= '0;
            r_alu_a   <= 16'h0;
            r_alu_b   <= 16'h0;
            r_alu_sel <= 2'd0;
            r_pass    <= 1'b0;
        end else begin
            r_start <= i_start && (r_state == ST_IDLE || r_state == ST_DONE);
            case (r_state)
                ST_IDLE: if (r_start) r_state <= ST_INIT;
                ST_INIT: begin
                    r_lfsr    <= LFSR_SEED;
                    r_cnt     <= '0;
                    r_alu_a   <= LFSR_SEED[31:16];
                    r_alu_b   <= LFSR_SEED[15:0];
                    r_alu_sel <= 2'd0;
                    r_pass    <= 1'b0;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (r_alu_sel != LAST_OP) begin
                        r_alu_sel <= r_alu_sel + 2'd1;
                    end else begin
                        r_alu_sel <= 2'd0;
                        r_cnt     <= r_cnt + CNT_W'(1);
                        r_lfsr    <= w_lfsr_next;
                        r_alu_a   <= w_lfsr_next[31:16];
                        r_alu_b   <= w_lfsr_next[15:0];
                        if (r_cnt == LAST_PAT) r_state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    r_pass  <= (w_sig == GOLDEN_SIG);
                    r_state <= ST_DONE;
                end
                ST_DONE: if (r_start) r_state <= ST_INIT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_sel   = r_alu_sel;
    assign o_test_mode = (r_state == ST_INIT) || (r_state == ST_RUN);
    assign o_busy      = (r_state == ST_INIT) || (r_state == ST_RUN) || (r_state == ST_CMP);
    assign o_done      = (r_state == ST_DONE);
    assign o_pass      = r_pass;
    assign o_signature = w_sig;

endmodule
